// File: rtl/ldpc_ber_tester_status_monitor.sv
// Decoder status pass-through with a 2-entry skid buffer plus decode statistics.
// Live counters are captured into snapshot registers on request so the regmap reads a coherent set.
module ldpc_ber_tester_status_monitor #(
    parameter int ID_W     = 8,
    parameter int ITER_LSB = 8,
    parameter int ITER_W   = 6,
    parameter int PASS_BIT = 14,
    parameter int CNT_W    = 48
) (
    input  logic              data_clk,
    input  logic              data_resetn,
    input  logic              clear,
    input  logic              snap,
    input  logic [31:0]       s_axis_status_tdata,
    input  logic              s_axis_status_tvalid,
    output logic              s_axis_status_tready,
    output logic [31:0]       m_axis_status_tdata,
    output logic              m_axis_status_tvalid,
    input  logic              m_axis_status_tready,
    output logic [CNT_W-1:0]  snap_blocks,
    output logic [CNT_W-1:0]  snap_parity_fail,
    output logic [63:0]       snap_iter_sum,
    output logic [ITER_W-1:0] snap_iter_max,
    output logic [ID_W-1:0]   snap_last_fail_id,
    output logic              snap_valid
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

    skid_state_t state_reg, state_next;
    logic [31:0] head_reg, head_next;
    logic [31:0] spare_reg, spare_next;
    logic        ready_reg;
    logic        accept;
    logic        pop;

    assign accept = s_axis_status_tvalid && ready_reg;
    assign pop    = (state_reg != EMPTY) && m_axis_status_tready;

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        spare_next = spare_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    head_next  = s_axis_status_tdata;
                end
            end
            ONE: begin
                case ({accept, pop})
                    2'b10: begin
                        state_next = TWO;
                        spare_next = s_axis_status_tdata;
                    end
                    2'b01:   state_next = EMPTY;
                    2'b11:   head_next  = s_axis_status_tdata;
                    default: state_next = ONE;
                endcase
            end
            TWO: begin
                if (pop) begin
                    state_next = ONE;
                    head_next  = spare_reg;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Ready is registered from the next state, so upstream never sees a path from m_tready.
    always_ff @(posedge data_clk or negedge data_resetn) begin
        if (!data_resetn) begin
            state_reg <= EMPTY;
            head_reg  <= '0;
            spare_reg <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            spare_reg <= spare_next;
            ready_reg <= (state_next != TWO);
        end
    end

    assign s_axis_status_tready = ready_reg;
    assign m_axis_status_tvalid = (state_reg != EMPTY);
    assign m_axis_status_tdata  = head_reg;

    logic              pend_reg;
    logic [ID_W-1:0]   pend_id_reg;
    logic [ITER_W-1:0] pend_iter_reg;
    logic              pend_pass_reg;

    logic [CNT_W-1:0]  blocks_reg, fail_reg;
    logic [63:0]       sum_reg;
    logic [ITER_W-1:0] max_reg;
    logic [ID_W-1:0]   last_id_reg;

    logic [CNT_W-1:0]  blocks_inc, fail_inc;
    logic [64:0]       sum_wide;
    logic [63:0]       sum_sat;

    assign blocks_inc = (&blocks_reg) ? blocks_reg : blocks_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    assign fail_inc   = (&fail_reg)   ? fail_reg   : fail_reg   + {{(CNT_W-1){1'b0}}, 1'b1};
    assign sum_wide   = {1'b0, sum_reg} + {{(65-ITER_W){1'b0}}, pend_iter_reg};
    assign sum_sat    = sum_wide[64] ? {64{1'b1}} : sum_wide[63:0];

    // The word accepted in the clear cycle is discarded together with any update landing then.
    always_ff @(posedge data_clk or negedge data_resetn) begin
        if (!data_resetn) begin
            pend_reg      <= 1'b0;
            pend_id_reg   <= '0;
            pend_iter_reg <= '0;
            pend_pass_reg <= 1'b0;
            blocks_reg    <= '0;
            fail_reg      <= '0;
            sum_reg       <= '0;
            max_reg       <= '0;
            last_id_reg   <= '0;
        end else begin
            pend_id_reg   <= s_axis_status_tdata[ID_W-1:0];
            pend_iter_reg <= s_axis_status_tdata[ITER_LSB +: ITER_W];
            pend_pass_reg <= s_axis_status_tdata[PASS_BIT];
            if (clear) begin
                pend_reg    <= 1'b0;
                blocks_reg  <= '0;
                fail_reg    <= '0;
                sum_reg     <= '0;
                max_reg     <= '0;
                last_id_reg <= '0;
            end else begin
                pend_reg <= accept;
                if (pend_reg) begin
                    blocks_reg <= blocks_inc;
                    sum_reg    <= sum_sat;
                    if (pend_iter_reg > max_reg)
                        max_reg <= pend_iter_reg;
                    if (!pend_pass_reg) begin
                        fail_reg    <= fail_inc;
                        last_id_reg <= pend_id_reg;
                    end
                end
            end
        end
    end

    always_ff @(posedge data_clk or negedge data_resetn) begin
        if (!data_resetn) begin
            snap_blocks       <= '0;
            snap_parity_fail  <= '0;
            snap_iter_sum     <= '0;
            snap_iter_max     <= '0;
            snap_last_fail_id <= '0;
            snap_valid        <= 1'b0;
        end else if (snap) begin
            snap_blocks       <= blocks_reg;
            snap_parity_fail  <= fail_reg;
            snap_iter_sum     <= sum_reg;
            snap_iter_max     <= max_reg;
            snap_last_fail_id <= last_id_reg;
            snap_valid        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ldpc_ber_tester_status_monitor.sv
// Randomized bench: stream and statistics checked against a queue/counter model.
// A second narrow-counter instance exercises counter saturation.
module tb_ldpc_ber_tester_status_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        snap = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        m_tready = 1'b0;

    logic        s_tready, m_tvalid;
    logic [31:0] m_tdata;
    logic [47:0] snap_blocks, snap_fail;
    logic [63:0] snap_sum;
    logic [5:0]  snap_max;
    logic [7:0]  snap_last;
    logic        snap_vld;

    logic        sm_s_tready, sm_m_tvalid;
    logic [31:0] sm_m_tdata;
    logic [2:0]  sm_blocks, sm_fail;
    logic [63:0] sm_sum;
    logic [5:0]  sm_max;
    logic [7:0]  sm_last;
    logic        sm_vld;

    always #5 clk = ~clk;

    ldpc_ber_tester_status_monitor dut (
        .data_clk(clk), .data_resetn(rst_n), .clear(clear), .snap(snap),
        .s_axis_status_tdata(s_tdata), .s_axis_status_tvalid(s_tvalid), .s_axis_status_tready(s_tready),
        .m_axis_status_tdata(m_tdata), .m_axis_status_tvalid(m_tvalid), .m_axis_status_tready(m_tready),
        .snap_blocks(snap_blocks), .snap_parity_fail(snap_fail), .snap_iter_sum(snap_sum),
        .snap_iter_max(snap_max), .snap_last_fail_id(snap_last), .snap_valid(snap_vld)
    );

    ldpc_ber_tester_status_monitor #(.CNT_W(3)) dut_small (
        .data_clk(clk), .data_resetn(rst_n), .clear(clear), .snap(snap),
        .s_axis_status_tdata(s_tdata), .s_axis_status_tvalid(s_tvalid), .s_axis_status_tready(sm_s_tready),
        .m_axis_status_tdata(sm_m_tdata), .m_axis_status_tvalid(sm_m_tvalid), .m_axis_status_tready(m_tready),
        .snap_blocks(sm_blocks), .snap_parity_fail(sm_fail), .snap_iter_sum(sm_sum),
        .snap_iter_max(sm_max), .snap_last_fail_id(sm_last), .snap_valid(sm_vld)
    );

    localparam logic [47:0] BIG_MAX = 48'hFFFF_FFFF_FFFF;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] fifo[$];
    bit          rst_hold;
    bit          last_acc;
    bit          pend_v;
    logic [31:0] pend_w;
    logic [47:0] m_blocks, m_fail;
    int          m_sm_blocks, m_sm_fail;
    logic [63:0] m_sum;
    logic [5:0]  m_max;
    logic [7:0]  m_last;
    logic [47:0] e_blocks, e_fail;
    int          e_sm_blocks, e_sm_fail;
    logic [63:0] e_sum;
    logic [5:0]  e_max;
    logic [7:0]  e_last;
    bit          e_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic zero_live();
        m_blocks = '0; m_fail = '0; m_sum = '0; m_max = '0; m_last = '0;
        m_sm_blocks = 0; m_sm_fail = 0;
        pend_v = 0;
    endtask

    task automatic model_reset();
        fifo.delete();
        zero_live();
        e_blocks = '0; e_fail = '0; e_sum = '0; e_max = '0; e_last = '0;
        e_sm_blocks = 0; e_sm_fail = 0; e_valid = 0;
        rst_hold = 1;
    endtask

    task automatic apply_word(input logic [31:0] w);
        logic [5:0] it;
        it = w[13:8];
        m_blocks    = (m_blocks == BIG_MAX) ? m_blocks : m_blocks + 48'd1;
        m_sm_blocks = (m_sm_blocks < 7) ? m_sm_blocks + 1 : 7;
        if (!w[14]) begin
            m_fail    = (m_fail == BIG_MAX) ? m_fail : m_fail + 48'd1;
            m_sm_fail = (m_sm_fail < 7) ? m_sm_fail + 1 : 7;
            m_last    = w[7:0];
        end
        m_sum = (~m_sum < 64'(it)) ? {64{1'b1}} : m_sum + 64'(it);
        if (it > m_max) m_max = it;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        bit er, ev, acc, pp;
        logic [31:0] w;
        er = !rst_hold && (fifo.size() < 2);
        ev = (fifo.size() != 0);
        check("s_tready", s_tready, er);
        check("m_tvalid", m_tvalid, ev);
        if (ev) check("m_tdata", m_tdata, fifo[0]);
        check("sm_m_tvalid", sm_m_tvalid, ev);
        check("snap_blocks", snap_blocks, e_blocks);
        check("snap_fail", snap_fail, e_fail);
        check("snap_sum", snap_sum, e_sum);
        check("snap_max", snap_max, e_max);
        check("snap_last", snap_last, e_last);
        check("snap_valid", snap_vld, e_valid);
        check("sm_blocks", sm_blocks, e_sm_blocks);
        check("sm_fail", sm_fail, e_sm_fail);
        check("sm_sum", sm_sum, e_sum);
        acc = s_tvalid && er;
        pp  = ev && m_tready;
        w   = s_tdata;
        @(posedge clk);
        if (snap) begin
            e_blocks = m_blocks; e_fail = m_fail; e_sum = m_sum; e_max = m_max; e_last = m_last;
            e_sm_blocks = m_sm_blocks; e_sm_fail = m_sm_fail; e_valid = 1;
        end
        if (clear) begin
            zero_live();
        end else begin
            if (pend_v) apply_word(pend_w);
            pend_v = acc;
            pend_w = w;
        end
        if (pp) void'(fifo.pop_front());
        if (acc) fifo.push_back(w);
        rst_hold = 0;
        last_acc = acc;
        @(negedge clk);
        clear = 1'b0;
        snap  = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [31:0] w, input bit do_clear);
        bit done;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = w;
            clear    = do_clear;
            cycle();
            done = last_acc;
        end
        if (!done) check("send_timeout", 0, 1);
        s_tvalid = 1'b0;
    endtask

    function automatic logic [31:0] mkword(input bit pass, input int iter, input int id);
        return (32'($urandom) & 32'hFFFF_8000) | (32'(pass) << 14) | (32'(iter & 63) << 8) | 32'(id & 255);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat[4];
        int sent;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_mtdata", m_tdata, 0);
        rst_n = 1'b1;
        idle(2);

        // Four known words, then snap
        m_tready = 1'b1;
        send(mkword(1, 3, 1), 0);
        send(mkword(0, 5, 2), 0);
        send(mkword(1, 2, 3), 0);
        send(mkword(0, 7, 4), 0);
        idle(1);
        snap = 1'b1;
        idle(1);
        check("t1_blocks", snap_blocks, 4);
        check("t1_fail", snap_fail, 2);
        check("t1_sum", snap_sum, 17);
        check("t1_max", snap_max, 7);
        check("t1_last", snap_last, 4);
        check("t1_valid", snap_vld, 1);

        // Ten words with downstream ready toggling
        sent = 0;
        for (int k = 0; k < 100 && sent < 10; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = mkword($urandom_range(0, 1), $urandom_range(0, 63), sent);
            m_tready = pat[k % 4];
            cycle();
            if (last_acc) sent++;
        end
        check("t2_sent", sent, 10);
        idle(3);

        // Saturation of the narrow counters
        clear = 1'b1;
        idle(1);
        for (int i = 0; i < 9; i++) send(mkword(0, i + 1, i), 0);
        idle(2);
        snap = 1'b1;
        idle(1);
        check("t3_blocks", snap_blocks, 9);
        check("t3_sm_blocks", sm_blocks, 7);
        check("t3_sum", snap_sum, 45);

        // Clear coinciding with a handshake
        for (int i = 0; i < 5; i++) send(mkword(1, 4, i), 0);
        idle(1);
        send(mkword(1, 9, 9), 1);
        idle(2);
        snap = 1'b1;
        idle(1);
        check("t4_blocks", snap_blocks, 0);

        // Snap and clear together
        for (int i = 0; i < 5; i++) send(mkword(0, 1, i), 0);
        idle(2);
        snap  = 1'b1;
        clear = 1'b1;
        idle(1);
        check("t5_blocks", snap_blocks, 5);
        idle(2);
        snap = 1'b1;
        idle(1);
        check("t5_blocks_after", snap_blocks, 0);

        // Random traffic with occasional clear and snap
        for (int k = 0; k < 300; k++) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = $urandom;
            m_tready = $urandom_range(0, 1);
            clear    = ($urandom_range(0, 15) == 0);
            snap     = ($urandom_range(0, 7) == 0);
            cycle();
        end
        idle(3);

        // Reset with two words buffered
        m_tready = 1'b0;
        for (int k = 0; k < 10 && fifo.size() < 2; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            cycle();
        end
        check("t6_buffered", fifo.size(), 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_mvalid", m_tvalid, 0);
        check("t6_rst_sready", s_tready, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        cycle();
        for (int k = 0; k < 40; k++) begin
            s_tvalid = $urandom_range(0, 1);
            s_tdata  = $urandom;
            m_tready = $urandom_range(0, 1);
            snap     = ($urandom_range(0, 5) == 0);
            cycle();
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
